// File: rtl/i2c_pkg.sv
// Shared defaults and counter widths for the i2c bus-side PHY.
// Stretch detection in i2c_bus_phy is built only when I2C_STRETCH_EN is defined.
package i2c_pkg;

    localparam int DIV_DEF  = 1;
    localparam int FILT_DEF = 3;
    localparam int RISE_DEF = 16;
    localparam int TMO_DEF  = 1048576;

    localparam int PRESC_W = 16;
    localparam int FILT_W  = 4;
    localparam int RISE_W  = 8;
    localparam int TMO_W   = 24;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus FILT-stable deglitch filter for one open-drain line.
// Both the synchroniser and the filtered output come out of reset at 1 (idle bus level).
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int FILT = FILT_DEF
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic pin,
    output logic filt
);

    logic              sync1;
    logic              sync2;
    logic [FILT_W-1:0] cnt;

    // A new level is accepted only after it has differed from filt for FILT samples.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            filt  <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (sync2 == filt) begin
                cnt <= '0;
            end else if (cnt == FILT_W'(FILT - 1)) begin
                filt <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + FILT_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2c_bus_phy.sv
// Open-drain pin stage for the i2c master: pin enables, filtered SDA return, CSTEP prescaler.
// Define I2C_STRETCH_EN to build slave clock-stretch detection and the sticky stretch timeout.
module i2c_bus_phy
    import i2c_pkg::*;
#(
    parameter int DIV  = DIV_DEF,
    parameter int FILT = FILT_DEF,
    parameter int RISE = RISE_DEF,
    parameter int TMO  = TMO_DEF
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic sclo,
    input  logic sdao,
    output logic sdai,
    output logic CSTEP,
    output logic scl_oe,
    output logic sda_oe,
    input  logic scl_pin,
    input  logic sda_pin,
    input  logic clrto,
    output logic stretch,
    output logic timeout
);

    logic               scl_f;
    logic               sda_f;
    logic [PRESC_W-1:0] presc;

    i2c_line_filter #(.FILT(FILT)) u_scl_filt (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .pin   (scl_pin),
        .filt  (scl_f)
    );

    i2c_line_filter #(.FILT(FILT)) u_sda_filt (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .pin   (sda_pin),
        .filt  (sda_f)
    );

    assign sdai = sda_f;

    // Pins are only ever pulled low; a released master level turns the driver off.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            scl_oe <= 1'b0;
            sda_oe <= 1'b0;
        end else begin
            scl_oe <= ~sclo;
            sda_oe <= ~sdao;
        end
    end

`ifdef I2C_STRETCH_EN
    logic [RISE_W-1:0] rise_cnt;
    logic [RISE_W-1:0] rise_next;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              stretch_next;
    logic              timeout_next;

    // stretch is registered from next-state values so it lines up with the saturating edge.
    always_comb begin
        rise_next = rise_cnt;
        if (scl_oe) begin
            rise_next = '0;
        end else if (rise_cnt != RISE_W'(RISE)) begin
            rise_next = rise_cnt + RISE_W'(1);
        end
        timeout_next = timeout | (stretch && (tmo_cnt == TMO_W'(TMO - 1)));
        if (clrto) begin
            timeout_next = 1'b0;
        end
        stretch_next = (rise_next == RISE_W'(RISE)) && !scl_f && !timeout_next;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            rise_cnt <= '0;
            tmo_cnt  <= '0;
            stretch  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            rise_cnt <= rise_next;
            stretch  <= stretch_next;
            timeout  <= timeout_next;
            if (clrto || !stretch) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end
`else
    logic unused_stretch_inputs;

    assign stretch = 1'b0;
    assign timeout = 1'b0;
    assign unused_stretch_inputs = clrto ^ scl_f ^ (RISE == 0) ^ (TMO == 0);
`endif

    // The prescaler freezes during a stretch so the master never steps past a held SCL.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            presc <= '0;
        end else if (!stretch) begin
            if (presc == PRESC_W'(DIV - 1)) begin
                presc <= '0;
            end else begin
                presc <= presc + PRESC_W'(1);
            end
        end
    end

    assign CSTEP = !stretch && (presc == PRESC_W'(DIV - 1));

endmodule
